ticket_arbiter: RTL and testbench

//  Admission side of the bank-queue system. NK ticket kiosks request entry for a new customer.

---
 rtl/ticket_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/ticket_arbiter.sv | 120 ++++++++++++
 tb/tb_ticket_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ticket_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ticket_pkg : shared FSM encodings and widths for the bank-queue blocks      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ticket_pkg;

  localparam int c_NW_DEFAULT = 4;
  localparam int c_TW_DEFAULT = 4;
  localparam int c_FIRST_NO   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational NK-way round-robin priority encoder                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NK = 4,
  parameter int PW = 2
) (
  input  logic [NK-1:0] req,
  input  logic [PW-1:0] rr_ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [PW-1:0] w_idx;

  // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      w_idx = PW'((int'(rr_ptr) + k) % NK);
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ticket_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ticket_arbiter : round-robin kiosk admission, numbers customers and writes |
// | {number, service time} into the customer FIFO.                             |
// | Option macro PRIO_K0_EN: kiosk 0 overrides round-robin.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ticket_arbiter
  import ticket_pkg::*;
#(
  parameter int NK = 4,
  parameter int NW = c_NW_DEFAULT,
  parameter int TW = c_TW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NK-1:0]    req,
  input  logic [NK*TW-1:0] kt,
  input  logic             full,
  output logic             we,
  output logic [NW-1:0]    wn,
  output logic [TW-1:0]    wt,
  output logic [NK-1:0]    gnt,
  output logic [NW-1:0]    tkt_no
);

  localparam int PW = (NK > 1) ? $clog2(NK) : 1;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_rr_ptr, r_win, w_win, w_rr_win, w_rr_adv;
  logic          w_rr_valid, w_valid, w_take;
  logic [NK-1:0] w_req_rr;
  logic [NW-1:0] r_next_no, w_next_adv;
  logic [TW-1:0] w_kt_sel, w_kt_clamped;

`ifdef PRIO_K0_EN
  // Kiosk 0 is removed from the rotation and simply overrides it.
  assign w_req_rr = {req[NK-1:1], 1'b0};
  assign w_win    = req[0] ? '0 : w_rr_win;
  assign w_valid  = req[0] | w_rr_valid;
`else
  assign w_req_rr = req;
  assign w_win    = w_rr_win;
  assign w_valid  = w_rr_valid;
`endif

  rr_pick #(
    .NK (NK),
    .PW (PW)
  ) u_rr_pick (
    .req    (w_req_rr),
    .rr_ptr (r_rr_ptr),
    .winner (w_rr_win),
    .valid  (w_rr_valid)
  );

  always_comb begin
    w_kt_sel = '0;
    for (int i = 0; i < NK; i++) begin
      if (w_win == PW'(i)) w_kt_sel = kt[i*TW +: TW];
    end
  end

  assign w_kt_clamped = (w_kt_sel == '0) ? TW'(1) : w_kt_sel;
  assign w_rr_adv     = (r_win == PW'(NK - 1)) ? '0 : r_win + 1'b1;
  // Number 0 means "idle" on the counters, so the sequence skips it.
  assign w_next_adv   = (r_next_no == '1) ? NW'(c_FIRST_NO) : r_next_no + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid && !full) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we        <= 1'b0;
      gnt       <= '0;
      wn        <= '0;
      wt        <= '0;
      tkt_no    <= '0;
      r_win     <= '0;
      r_rr_ptr  <= '0;
      r_next_no <= NW'(c_FIRST_NO);
    end else if (w_take) begin
      we     <= 1'b1;
      gnt    <= NK'(1) << w_win;
      wn     <= r_next_no;
      wt     <= w_kt_clamped;
      tkt_no <= r_next_no;
      r_win  <= w_win;
    end else if (r_state == ISSUE) begin
      we        <= 1'b0;
      gnt       <= '0;
      r_next_no <= w_next_adv;
`ifdef PRIO_K0_EN
      if (r_win != '0) r_rr_ptr <= w_rr_adv;
`else
      r_rr_ptr  <= w_rr_adv;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ticket_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ticket_arbiter : scoreboard bench for ticket_arbiter                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ticket_arbiter;

  localparam int NK = 4;
  localparam int NW = 4;
  localparam int TW = 4;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic [NK-1:0]    req  = '0;
  logic [NK*TW-1:0] kt   = '0;
  logic             full = 1'b0;
  logic             we;
  logic [NW-1:0]    wn;
  logic [TW-1:0]    wt;
  logic [NK-1:0]    gnt;
  logic [NW-1:0]    tkt_no;

  typedef struct {
    logic [NK-1:0] g;
    logic [NW-1:0] n;
    logic [TW-1:0] t;
    int            c;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  ticket_arbiter #(.NK(NK), .NW(NW), .TW(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .kt     (kt),
    .full   (full),
    .we     (we),
    .wn     (wn),
    .wt     (wt),
    .gnt    (gnt),
    .tkt_no (tkt_no)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic set_kt(input int i, input logic [TW-1:0] v);
    kt[i*TW +: TW] = v;
  endtask

  task automatic expect_grant(input logic [NK-1:0] g, input logic [NW-1:0] n,
                              input logic [TW-1:0] t, input int c);
    exp_t e;
    e.g = g; e.n = n; e.t = t; e.c = c;
    q.push_back(e);
  endtask

  // Kiosk behaviour: drop req on its own gnt; then let SETTLE pass back to IDLE.
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (req != '0 && k < budget) begin
      @(negedge clk);
      req = req & ~gnt;
      k++;
    end
    check("drain_timeout", req == '0, $sformatf("req=%b after %0d cycles, required 0000", req, k));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (we || gnt != '0)) begin
          if (q.size() == 0) begin
            check("unexpected_write", 1'b0,
                  $sformatf("we=%0b gnt=%b wn=%0d, required no write", we, gnt, wn));
          end else begin
            e = q.pop_front();
            check("grant", we && gnt == e.g && wn == e.n && wt == e.t && tkt_no == e.n && cyc == e.c,
                  $sformatf("we=%0b gnt=%b wn=%0d wt=%0d tkt_no=%0d cyc=%0d, required gnt=%b wn=%0d wt=%0d cyc=%0d",
                            we, gnt, wn, wt, tkt_no, cyc, e.g, e.n, e.t, e.c));
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_we",     we == 1'b0,  $sformatf("we=%0b, required 0", we));
    check("rst_gnt",    gnt == '0,   $sformatf("gnt=%b, required 0000", gnt));
    check("rst_wn",     wn == '0,    $sformatf("wn=%0d, required 0", wn));
    check("rst_wt",     wt == '0,    $sformatf("wt=%0d, required 0", wt));
    check("rst_tkt_no", tkt_no == '0, $sformatf("tkt_no=%0d, required 0", tkt_no));
    rst = 1'b0;
    @(negedge clk);

    // single request
    set_kt(0, 4'd5);
    req = 4'b0001;
    expect_grant(4'b0001, 4'd1, 4'd5, cyc + 1);
    drain(10);

    // reset while in ISSUE
    set_kt(1, 4'd6);
    req = 4'b0010;
    expect_grant(4'b0010, 4'd2, 4'd6, cyc + 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_we",  we == 1'b0, $sformatf("we=%0b, required 0", we));
    check("midrst_gnt", gnt == '0,  $sformatf("gnt=%b, required 0000", gnt));
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // contention from reset: 0,1,2,3 at 3-cycle spacing, kt2=0 clamps to 1
    set_kt(0, 4'd7); set_kt(1, 4'd3); set_kt(2, 4'd0); set_kt(3, 4'd9);
    req = 4'b1111;
    c = cyc;
    expect_grant(4'b0001, 4'd1, 4'd7, c + 1);
    expect_grant(4'b0010, 4'd2, 4'd3, c + 4);
    expect_grant(4'b0100, 4'd3, 4'd1, c + 7);
    expect_grant(4'b1000, 4'd4, 4'd9, c + 10);
    drain(20);

    // full stall then release
    full = 1'b1;
    set_kt(2, 4'd8);
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_no_write", we == 1'b0 && gnt == '0, $sformatf("we=%0b gnt=%b, required 0/0000", we, gnt));
    end
    full = 1'b0;
    expect_grant(4'b0100, 4'd5, 4'd8, cyc + 1);
    drain(10);

    // withdrawn request while full: no ticket, numbering untouched
    full = 1'b1;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    req = '0;
    full = 1'b0;
    repeat (4) @(negedge clk);

    // advance to 15, then wrap with kt=0 clamp
    for (int n = 6; n <= 14; n++) begin
      set_kt(0, 4'd2);
      req = 4'b0001;
      expect_grant(4'b0001, 4'(n), 4'd2, cyc + 1);
      drain(10);
    end
    set_kt(3, 4'd0);
    req = 4'b1000;
    expect_grant(4'b1000, 4'd15, 4'd1, cyc + 1);
    drain(10);
    set_kt(1, 4'd15);
    req = 4'b0010;
    expect_grant(4'b0010, 4'd1, 4'd15, cyc + 1);
    drain(10);

    // rr_ptr is now 2
    set_kt(0, 4'd1); set_kt(2, 4'd2);
    req = 4'b0101;
    c = cyc;
`ifdef PRIO_K0_EN
    expect_grant(4'b0001, 4'd2, 4'd1, c + 1);
    expect_grant(4'b0100, 4'd3, 4'd2, c + 4);
`else
    expect_grant(4'b0100, 4'd2, 4'd2, c + 1);
    expect_grant(4'b0001, 4'd3, 4'd1, c + 4);
`endif
    drain(20);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size() == 0, $sformatf("%0d grants outstanding, required 0", q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
